// File: rtl/spi_sched_pkg.sv
// Shared register map, SPI core bit positions and FSM encoding for the
// SPI byte-transfer scheduler.
package spi_sched_pkg;

    localparam logic [7:0] ADR_SPCR = 8'd0;
    localparam logic [7:0] ADR_SPSR = 8'd1;
    localparam logic [7:0] ADR_SPDR = 8'd2;
    localparam logic [7:0] ADR_SPER = 8'd3;

    localparam int SPSR_RFEMPTY = 0;
    localparam int SPSR_SPIF    = 7;
    localparam int SPCR_SPIE    = 7;
    localparam int SPCR_SPE     = 6;
    localparam int SPCR_MSTR    = 4;

    // Writing a one to SPIF clears it.
    localparam logic [7:0] SPSR_CLR = 8'h80;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CFG_SPER,
        ST_CFG_SPCR,
        ST_GRANT,
        ST_WR_SPDR,
        ST_POLL,
        ST_RD_SPDR,
        ST_CLR_SPIF,
        ST_RESP
    } state_t;

    function automatic logic [7:0] spcr_value(input logic [1:0] mode, input logic [1:0] spr);
        logic [7:0] v;
        v            = 8'h00;
        v[SPCR_SPIE] = 1'b0;
        v[SPCR_SPE]  = 1'b1;
        v[SPCR_MSTR] = 1'b1;
        v[3:2]       = mode;
        v[1:0]       = spr;
        return v;
    endfunction

endpackage

// File: rtl/spi_rr_arb2.sv
// Two-way round-robin arbiter; on a tie the requester not granted last wins.
module spi_rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       take,
    output logic [1:0] gnt
);

    logic last;

    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = last ? 2'b01 : 2'b10;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last <= 1'b1;
        end else if (take && (gnt != 2'b00)) begin
            last <= gnt[1];
        end
    end

endmodule

// File: rtl/spi_xfer_sched.sv
// Schedules single-byte SPI transfers for two requesters through a Wishbone
// master port into an SPI core, including core configuration and RX polling.
//
//   state       | meaning
//   ------------+---------------------------------------------------------
//   IDLE        | waiting; pending config beats requests
//   CFG_SPER    | write extended divider bits to SPER
//   CFG_SPCR    | write mode/divider/enable to SPCR
//   GRANT       | req_ready strobe to winner, capture its TX byte
//   WR_SPDR     | write TX byte to SPDR
//   POLL        | read SPSR until RFEMPTY=0 or poll budget exhausted
//   RD_SPDR     | read RX byte from SPDR
//   CLR_SPIF    | write SPSR=0x80 to clear SPIF
//   RESP        | rsp_valid strobe to the granted requester
module spi_xfer_sched
    import spi_sched_pkg::*;
#(
    parameter int POLL_MAX = 1023,
    parameter int NREQ     = 2
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              cfg_load,
    input  logic [1:0]        cfg_mode,
    input  logic [3:0]        cfg_div,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [8*NREQ-1:0] req_data,
    output logic [NREQ-1:0]   req_ready,
    output logic [NREQ-1:0]   rsp_valid,
    output logic [7:0]        rsp_data,
    output logic              rsp_err,
    output logic              m_cyc_o,
    output logic              m_stb_o,
    output logic              m_we_o,
    output logic [7:0]        m_adr_o,
    output logic [7:0]        m_dat_o,
    input  logic [7:0]        m_dat_i,
    input  logic              m_ack_i,
    output logic              busy_o
);

    localparam int PW = $clog2(POLL_MAX + 1);

    state_t        state;
    logic          cfg_pend;
    logic          configured;
    logic [1:0]    mode_q;
    logic [3:0]    div_q;
    logic          sel;
    logic [7:0]    tx_q;
    logic [7:0]    rx_q;
    logic [PW-1:0] poll_left;
    logic [1:0]    gnt;
    logic          take;
    logic          acc_we;
    logic [7:0]    acc_adr;
    logic [7:0]    acc_dat;

    assign take   = (state == ST_IDLE) && !cfg_pend && configured && (req_valid != '0);
    assign busy_o = (state != ST_IDLE);

    spi_rr_arb2 u_arb (
        .clk  (wb_clk_i),
        .rst  (wb_rst_i),
        .req  (req_valid),
        .take (take),
        .gnt  (gnt)
    );

    // Bus access parameters for whichever access state is current.
    always_comb begin
        acc_we  = 1'b1;
        acc_adr = ADR_SPDR;
        acc_dat = tx_q;
        case (state)
            ST_CFG_SPER: begin acc_adr = ADR_SPER; acc_dat = {6'b0, div_q[3:2]}; end
            ST_CFG_SPCR: begin acc_adr = ADR_SPCR; acc_dat = spcr_value(mode_q, div_q[1:0]); end
            ST_POLL:     begin acc_we = 1'b0; acc_adr = ADR_SPSR; acc_dat = 8'h00; end
            ST_RD_SPDR:  begin acc_we = 1'b0; acc_adr = ADR_SPDR; acc_dat = 8'h00; end
            ST_CLR_SPIF: begin acc_adr = ADR_SPSR; acc_dat = SPSR_CLR; end
            default: ;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state      <= ST_IDLE;
            cfg_pend   <= 1'b0;
            configured <= 1'b0;
            mode_q     <= 2'b00;
            div_q      <= 4'h0;
            sel        <= 1'b0;
            tx_q       <= 8'h00;
            rx_q       <= 8'h00;
            poll_left  <= '0;
            req_ready  <= '0;
            rsp_valid  <= '0;
            rsp_data   <= 8'h00;
            rsp_err    <= 1'b0;
            m_cyc_o    <= 1'b0;
            m_stb_o    <= 1'b0;
            m_we_o     <= 1'b0;
            m_adr_o    <= 8'h00;
            m_dat_o    <= 8'h00;
        end else begin
            req_ready <= '0;
            rsp_valid <= '0;
            case (state)
                ST_IDLE: begin
                    if (cfg_pend) begin
                        state <= ST_CFG_SPER;
                    end else if (take) begin
                        state     <= ST_GRANT;
                        req_ready <= gnt;
                        sel       <= gnt[1];
                    end
                end
                ST_GRANT: begin
                    tx_q      <= req_data[{sel, 3'b000} +: 8];
                    poll_left <= PW'(POLL_MAX);
                    state     <= ST_WR_SPDR;
                end
                ST_RESP: state <= ST_IDLE;
                default: begin
                    // Every access state: launch, hold until ack, then drop for a cycle.
                    if (!m_cyc_o) begin
                        m_cyc_o <= 1'b1;
                        m_stb_o <= 1'b1;
                        m_we_o  <= acc_we;
                        m_adr_o <= acc_adr;
                        m_dat_o <= acc_dat;
                    end else if (m_ack_i) begin
                        m_cyc_o <= 1'b0;
                        m_stb_o <= 1'b0;
                        m_we_o  <= 1'b0;
                        case (state)
                            ST_CFG_SPER: state <= ST_CFG_SPCR;
                            ST_CFG_SPCR: begin
                                cfg_pend   <= 1'b0;
                                configured <= 1'b1;
                                state      <= ST_IDLE;
                            end
                            ST_WR_SPDR: state <= ST_POLL;
                            ST_POLL: begin
                                if (!m_dat_i[SPSR_RFEMPTY]) begin
                                    state <= ST_RD_SPDR;
                                end else if (poll_left == PW'(1)) begin
                                    rsp_valid <= NREQ'(1) << sel;
                                    rsp_err   <= 1'b1;
                                    rsp_data  <= 8'h00;
                                    state     <= ST_RESP;
                                end else begin
                                    poll_left <= poll_left - PW'(1);
                                end
                            end
                            ST_RD_SPDR: begin
                                rx_q  <= m_dat_i;
                                state <= ST_CLR_SPIF;
                            end
                            ST_CLR_SPIF: begin
                                rsp_valid <= NREQ'(1) << sel;
                                rsp_err   <= 1'b0;
                                rsp_data  <= rx_q;
                                state     <= ST_RESP;
                            end
                            default: state <= ST_IDLE;
                        endcase
                    end
                end
            endcase
            // Config requests are remembered whatever the FSM is doing.
            if (cfg_load) begin
                cfg_pend <= 1'b1;
                mode_q   <= cfg_mode;
                div_q    <= cfg_div;
            end
        end
    end

endmodule

// File: tb/tb_spi_xfer_sched.sv
// Directed bench for spi_xfer_sched with a Wishbone SPI-core slave model.
module tb_spi_xfer_sched;

    logic wb_clk_i = 1'b0;
    always #5 wb_clk_i = ~wb_clk_i;

    logic        wb_rst_i, cfg_load;
    logic [1:0]  cfg_mode;
    logic [3:0]  cfg_div;
    logic [1:0]  req_valid, req_ready, rsp_valid;
    logic [15:0] req_data;
    logic [7:0]  rsp_data, m_adr_o, m_dat_o, m_dat_i;
    logic        rsp_err, m_cyc_o, m_stb_o, m_we_o, m_ack_i, busy_o;

    spi_xfer_sched #(.POLL_MAX(4), .NREQ(2)) dut (
        .wb_clk_i (wb_clk_i), .wb_rst_i (wb_rst_i),
        .cfg_load (cfg_load), .cfg_mode (cfg_mode), .cfg_div (cfg_div),
        .req_valid(req_valid), .req_data (req_data), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_data (rsp_data), .rsp_err  (rsp_err),
        .m_cyc_o  (m_cyc_o), .m_stb_o  (m_stb_o), .m_we_o   (m_we_o),
        .m_adr_o  (m_adr_o), .m_dat_o  (m_dat_o), .m_dat_i  (m_dat_i),
        .m_ack_i  (m_ack_i), .busy_o   (busy_o)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Slave model: SPSR read number poll_ok reports RFEMPTY=0 (0 = never).
    typedef struct { logic we; logic [7:0] adr; logic [7:0] dat; } acc_t;
    acc_t       log_q[$];
    acc_t       acc_tmp;
    int         grant_q[$];
    int         ack_delay = 0, poll_ok = 0;
    logic [7:0] spdr_rx = 8'h00;
    logic       slv_clr = 1'b0;
    int         wcnt = 0, spsr_reads = 0, run = 0, min_run = 1000, max_run = 0, rsp_cnt = 0, viol = 0;
    logic       prev_ack = 1'b0;
    logic [1:0] prev_ready = 2'b00, prev_rsp = 2'b00;
    logic       rfempty;

    assign m_ack_i = m_cyc_o && m_stb_o && (wcnt == ack_delay);

    always_comb begin
        rfempty = !(poll_ok != 0 && spsr_reads + 1 >= poll_ok);
        m_dat_i = 8'h00;
        if (m_adr_o == 8'd1) m_dat_i = {7'b0, rfempty};
        else if (m_adr_o == 8'd2) m_dat_i = spdr_rx;
    end

    always @(posedge wb_clk_i) begin
        if (slv_clr) begin
            wcnt <= 0; spsr_reads <= 0; run <= 0; min_run <= 1000; max_run <= 0; rsp_cnt <= 0;
            log_q.delete();
            grant_q.delete();
        end else begin
            if (m_cyc_o && m_stb_o) begin
                if (m_ack_i) begin
                    acc_tmp.we = m_we_o; acc_tmp.adr = m_adr_o; acc_tmp.dat = m_dat_o;
                    log_q.push_back(acc_tmp);
                    if (!m_we_o && m_adr_o == 8'd1) spsr_reads <= spsr_reads + 1;
                    if (run + 1 > max_run) max_run <= run + 1;
                    if (run + 1 < min_run) min_run <= run + 1;
                    run <= 0; wcnt <= 0;
                end else begin
                    run <= run + 1; wcnt <= wcnt + 1;
                end
            end
            if (req_ready[0]) grant_q.push_back(0);
            if (req_ready[1]) grant_q.push_back(1);
            if (rsp_valid != 2'b00) rsp_cnt <= rsp_cnt + 1;
        end
        viol <= viol + int'(prev_ack && m_cyc_o)
                     + int'((prev_ready & req_ready) != 2'b00 || (prev_rsp & rsp_valid) != 2'b00)
                     + int'(req_ready == 2'b11 || rsp_valid == 2'b11);
        prev_ack   <= m_ack_i;
        prev_ready <= req_ready;
        prev_rsp   <= rsp_valid;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge wb_clk_i);
    endtask

    task automatic clear_slave();
        slv_clr = 1'b1;
        @(negedge wb_clk_i);
        slv_clr = 1'b0;
    endtask

    task automatic wait_rsp();
        for (int k = 0; k < 400 && rsp_valid == 2'b00; k++) @(negedge wb_clk_i);
    endtask

    task automatic do_cfg(input logic [1:0] mode, input logic [3:0] div,
                          input logic [7:0] exp_sper, input logic [7:0] exp_spcr);
        int n;
        clear_slave();
        cfg_mode = mode; cfg_div = div; cfg_load = 1'b1;
        @(negedge wb_clk_i);
        cfg_load = 1'b0; cfg_mode = 2'b00; cfg_div = 4'h0;
        n = 0;
        while (!busy_o && n < 20) begin @(negedge wb_clk_i); n++; end
        while (busy_o && n < 200) begin @(negedge wb_clk_i); n++; end
        check("cfg_busy_low", 32'(busy_o), 32'd0);
        check("cfg_nacc", log_q.size(), 32'd2);
        if (log_q.size() >= 2) begin
            check("cfg_sper", {log_q[0].we, log_q[0].adr, log_q[0].dat}, {1'b1, 8'd3, exp_sper});
            check("cfg_spcr", {log_q[1].we, log_q[1].adr, log_q[1].dat}, {1'b1, 8'd0, exp_spcr});
        end
    endtask

    typedef struct {
        logic [1:0]  rv;
        logic [15:0] data;
        int          pok;
        logic [7:0]  rx;
        int          dly;
        logic [1:0]  exp_rsp;
        logic [7:0]  exp_data;
        logic        exp_err;
        int          exp_polls;
    } vec_t;
    vec_t vecs[5];

    initial begin
        int n;
        logic [7:0] tx;
        // rv, data, poll_ok, rx, ack delay -> rsp_valid, rsp_data, rsp_err, SPSR reads
        vecs[0] = '{2'b01, 16'h00A5, 3, 8'h3C, 0, 2'b01, 8'h3C, 1'b0, 3};
        vecs[1] = '{2'b10, 16'h5A00, 1, 8'hC3, 0, 2'b10, 8'hC3, 1'b0, 1};
        vecs[2] = '{2'b01, 16'h0011, 0, 8'h77, 0, 2'b01, 8'h00, 1'b1, 4};
        vecs[3] = '{2'b10, 16'hE700, 2, 8'h99, 3, 2'b10, 8'h99, 1'b0, 2};
        vecs[4] = '{2'b11, 16'h1234, 4, 8'hCD, 0, 2'b01, 8'hCD, 1'b0, 4};

        wb_rst_i = 1'b1; cfg_load = 1'b0; cfg_mode = 2'b00; cfg_div = 4'h0;
        req_valid = 2'b00; req_data = 16'h0000;
        tick(3);
        wb_rst_i = 1'b0;
        check("reset_ctl", {req_ready, rsp_valid, rsp_err, m_cyc_o, m_stb_o, m_we_o, busy_o}, 32'd0);
        check("reset_rsp_data", rsp_data, 32'd0);
        check("reset_adr_dat", {m_adr_o, m_dat_o}, 32'd0);

        // Requests refused before the first configuration.
        clear_slave();
        req_valid = 2'b01; req_data = 16'h00FF;
        tick(10);
        check("unconfigured_no_grant", grant_q.size(), 32'd0);
        check("unconfigured_idle", 32'(busy_o), 32'd0);
        req_valid = 2'b00;

        do_cfg(2'b01, 4'b0110, 8'h01, 8'h56);

        // Both held valid: strict alternation starting with requester 0.
        clear_slave();
        poll_ok = 1; spdr_rx = 8'h42; req_data = 16'hBBAA; req_valid = 2'b11;
        n = 0;
        for (int k = 0; k < 600 && n < 4; k++) begin
            @(negedge wb_clk_i);
            if (rsp_valid != 2'b00) n++;
        end
        req_valid = 2'b00;
        tick(5);
        check("rr_ngrants", grant_q.size(), 32'd4);
        if (grant_q.size() >= 4) begin
            check("rr_g0", grant_q[0], 32'd0);
            check("rr_g1", grant_q[1], 32'd1);
            check("rr_g2", grant_q[2], 32'd0);
            check("rr_g3", grant_q[3], 32'd1);
        end

        // Reset while polling aborts the access and drops configuration.
        clear_slave();
        poll_ok = 0; req_data = 16'h0066; req_valid = 2'b01;
        n = 0;
        while (!(m_cyc_o && !m_we_o && m_adr_o == 8'd1) && n < 100) begin @(negedge wb_clk_i); n++; end
        check("abort_reached_poll", 32'(n < 100), 32'd1);
        wb_rst_i = 1'b1;
        @(negedge wb_clk_i);
        wb_rst_i = 1'b0;
        check("abort_cyc_stb", {m_cyc_o, m_stb_o}, 32'd0);
        check("abort_busy", 32'(busy_o), 32'd0);
        tick(20);
        check("abort_no_rsp", rsp_cnt, 32'd0);
        check("abort_no_regrant", grant_q.size(), 32'd1);
        req_valid = 2'b00;

        do_cfg(2'b10, 4'b1011, 8'h02, 8'h5B);

        for (int i = 0; i < 5; i++) begin
            clear_slave();
            poll_ok = vecs[i].pok; spdr_rx = vecs[i].rx; ack_delay = vecs[i].dly;
            req_data = vecs[i].data; req_valid = vecs[i].rv;
            wait_rsp();
            req_valid = 2'b00;
            check($sformatf("v%0d_rsp_valid", i), rsp_valid, vecs[i].exp_rsp);
            check($sformatf("v%0d_rsp_data", i), rsp_data, vecs[i].exp_data);
            check($sformatf("v%0d_rsp_err", i), 32'(rsp_err), 32'(vecs[i].exp_err));
            @(negedge wb_clk_i);
            check($sformatf("v%0d_rsp_pulse", i), rsp_valid, 32'd0);
            tick(3);
            check($sformatf("v%0d_polls", i), spsr_reads, vecs[i].exp_polls);
            check($sformatf("v%0d_nacc", i), log_q.size(),
                  vecs[i].exp_err ? vecs[i].exp_polls + 1 : vecs[i].exp_polls + 3);
            tx = vecs[i].exp_rsp[1] ? vecs[i].data[15:8] : vecs[i].data[7:0];
            if (log_q.size() >= 1)
                check($sformatf("v%0d_wr_spdr", i), {log_q[0].we, log_q[0].adr, log_q[0].dat}, {1'b1, 8'd2, tx});
            if (!vecs[i].exp_err && log_q.size() >= 1)
                check($sformatf("v%0d_clr_spif", i),
                      {log_q[log_q.size()-1].we, log_q[log_q.size()-1].adr, log_q[log_q.size()-1].dat},
                      {1'b1, 8'd1, 8'h80});
            check($sformatf("v%0d_stb_min", i), min_run, vecs[i].dly + 1);
            check($sformatf("v%0d_stb_max", i), max_run, vecs[i].dly + 1);
            check($sformatf("v%0d_ngrant", i), grant_q.size(), 32'd1);
            if (grant_q.size() >= 1)
                check($sformatf("v%0d_grant", i), grant_q[0], 32'(vecs[i].exp_rsp[1]));
            ack_delay = 0;
        end

        check("bus_protocol_violations", viol, 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/spi_xfer_sched.md
SPI_XFER_SCHED -- requirements
Module: spi_xfer_sched

Interface
REQ-001 SHALL have parameter POLL_MAX, default 1023, meaning the maximum number of SPSR polls per byte before timeout.
REQ-002 SHALL have parameter NREQ, default 2 (fixed), meaning the number of byte-transfer requesters.
REQ-003 SHALL have port wb_clk_i  in  1  the single clock; all logic is on its rising edge.
REQ-004 SHALL have port wb_rst_i  in  1  reset, synchronous and active-high.
REQ-005 SHALL have port cfg_load  in  1  one-cycle pulse requesting an SPI core (re)configuration.
REQ-006 SHALL have port cfg_mode  in  2  {CPOL,CPHA}, sampled when cfg_load=1.
REQ-007 SHALL have port cfg_div  in  4  {ESPR[1:0],SPR[1:0]} clock divider, sampled when cfg_load=1.
REQ-008 SHALL have port req_valid  in  2  per-requester transfer request.
REQ-009 SHALL have port req_data  in  16  TX bytes; requester i uses bits [8i+7:8i].
REQ-010 SHALL have port req_ready  out  2  one-cycle grant/accept strobe per requester.
REQ-011 SHALL have port rsp_valid  out  2  one-cycle completion strobe per requester.
REQ-012 SHALL have port rsp_data  out  8  RX byte, valid with rsp_valid.
REQ-013 SHALL have port rsp_err  out  1  timeout flag, valid with rsp_valid.
REQ-014 SHALL have port m_cyc_o, m_stb_o, m_we_o  out  1 each  Wishbone master controls to the SPI core.
REQ-015 SHALL have port m_adr_o  out  8  register address (0 SPCR, 1 SPSR, 2 SPDR, 3 SPER).
REQ-016 SHALL have ports m_dat_o  out  8  write data; m_dat_i  in  8  read data; m_ack_i  in  1  bus acknowledge.
REQ-017 SHALL have port busy_o  out  1  high in every state except IDLE.

Function
REQ-018 SHALL run the FSM IDLE, CFG_SPER, CFG_SPCR, GRANT, WR_SPDR, POLL, RD_SPDR, CLR_SPIF, RESP.
REQ-019 SHALL perform each bus access by holding cyc/stb (and we/adr/dat) constant until the cycle in which m_ack_i=1, deasserting them in the following cycle; at most one access is outstanding.
REQ-020 SHALL latch a pending-config flag on cfg_load in any state; from IDLE, a pending config takes priority over requests.
REQ-021 SHALL write SPER={6'b0,cfg_div[3:2]}, then SPCR={1'b0,1'b1,1'b0,1'b1,cfg_mode,cfg_div[1:0]} (SPE=1, MSTR=1, SPIE=0), then clear the pending flag and return to IDLE.
REQ-022 SHALL refuse all requests until the first configuration completes after reset.
REQ-023 SHALL arbitrate round-robin in IDLE: the requester not most recently granted wins a tie; the last-grant pointer resets to 1, so requester 0 wins the first tie.
REQ-024 SHALL in GRANT pulse req_ready for the winner for exactly one cycle and capture its byte; req_data is don't-care afterwards.
REQ-025 SHALL write the captured byte to SPDR (adr 2), then read SPSR (adr 1) repeatedly until bit0 (RFEMPTY)=0.
REQ-026 SHALL count SPSR reads in a counter of width clog2(POLL_MAX+1); if POLL_MAX reads all show RFEMPTY=1, it SHALL go to RESP with rsp_err=1 and rsp_data=8'h00.
REQ-027 SHALL on success read SPDR into rsp_data, write SPSR=8'h80 to clear SPIF, then go to RESP with rsp_err=0.
REQ-028 SHALL in RESP pulse rsp_valid for the granted requester for one cycle, then return to IDLE.
REQ-029 SHALL not re-grant a requester earlier than the cycle after its rsp_valid; a requester holding req_valid gets back-to-back transfers only if the other is idle.
REQ-030 SHALL keep a cfg_load arriving mid-transfer pending until the current transfer's RESP is done.

Reset
REQ-031 SHALL on wb_rst_i=1 at a clock edge force IDLE, clear all outputs to 0 (rsp_data=8'h00), clear the pending-config and configured flags and the poll counter, and set the last-grant pointer to 1.
REQ-032 SHALL abort any bus cycle immediately on reset (cyc/stb low the next cycle) with no rsp_valid issued for the aborted transfer.

Structure
REQ-033 SHALL take the register addresses, SPSR/SPCR bit positions and the FSM state encoding from a shared package, spi_sched_pkg.
REQ-034 SHALL have one sub-module, spi_rr_arb2 (2-way round-robin arbiter with a last-grant pointer).

Verification
REQ-035 SHALL cover: reset, then cfg_load with mode=2'b01, div=4'b0110 -> writes SPER=8'h01, then SPCR=8'h56, busy_o=0 afterwards.
REQ-036 SHALL cover: req_valid=2'b01, data 8'hA5, slave model returns RFEMPTY=0 on the third poll with SPDR=8'h3C -> three SPSR reads, rsp_valid=2'b01, rsp_data=8'h3C, rsp_err=0, SPSR write of 8'h80.
REQ-037 SHALL cover: both requesters held valid for four transfers -> grants in the order 0,1,0,1.
REQ-038 SHALL cover: RFEMPTY stuck at 1, POLL_MAX=4 -> exactly 4 SPSR reads, then rsp_err=1, rsp_data=8'h00.
REQ-039 SHALL cover: a 3-cycle ack delay on every access -> stb held for 4 cycles per access, no duplicate access.
REQ-040 SHALL cover: wb_rst_i asserted during POLL -> cyc/stb low the next cycle, no rsp_valid, requests refused until reconfigured.
